// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Responder side of the pipeline memory request interface. Instruction and
// data requests (level signals, held until their hit) are arbitrated onto a
// single-ported, variable-latency RAM. Data accesses win over instruction
// fetches. Each completed access produces a one-cycle ihit/dhit pulse. A
// watchdog traps a RAM that never raises ram_ready.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   halt            suppresses new instruction requests
//   iREN, iaddr     instruction read request / address
//   ihit, iload     instruction completion pulse / data (valid with ihit)
//   dREN, dWEN      data read / write request (both high = write)
//   daddr, dstore   data address / write data
//   dhit, dload     data completion pulse / read data (valid with dhit)
//   ramREN, ramWEN  RAM read / write strobes
//   ramaddr         RAM address
//   ramstore        RAM write data
//   ramload         RAM read data (valid with ram_ready)
//   ram_ready       RAM completes the current access this cycle
//   mem_err         sticky watchdog error flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          halt,
   input  logic          iREN,
   input  logic [AW-1:0] iaddr,
   output logic          ihit,
   output logic [DW-1:0] iload,
   input  logic          dREN,
   input  logic          dWEN,
   input  logic [AW-1:0] daddr,
   input  logic [DW-1:0] dstore,
   output logic          dhit,
   output logic [DW-1:0] dload,
   output logic          ramREN,
   output logic          ramWEN,
   output logic [AW-1:0] ramaddr,
   output logic [DW-1:0] ramstore,
   input  logic [DW-1:0] ramload,
   input  logic          ram_ready,
   output logic          mem_err
);

   localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      DACC,
      IACC,
      HIT,
      ERR
   } state_t;

   state_t        state;
   logic [CW-1:0] wd_cnt;
   logic          is_write;
   logic [DW-1:0] result;
   logic          ihit_q;
   logic          dhit_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         wd_cnt   <= '0;
         is_write <= 1'b0;
         result   <= '0;
         ihit_q   <= 1'b0;
         dhit_q   <= 1'b0;
         ramREN   <= 1'b0;
         ramWEN   <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            // Request sampling: address/data are captured only here, so
            // anything the requester changes mid-access is ignored.
            IDLE: begin
               wd_cnt <= '0;
               if (dREN || dWEN) begin
                  state    <= DACC;
                  is_write <= dWEN;
                  ramaddr  <= daddr;
                  ramstore <= dstore;
                  ramWEN   <= dWEN;
                  ramREN   <= ~dWEN;
               end else if (iREN && !halt) begin
                  state    <= IACC;
                  is_write <= 1'b0;
                  ramaddr  <= iaddr;
                  ramstore <= '0;
                  ramREN   <= 1'b1;
               end
            end
            // RAM access: strobes held until ram_ready or watchdog expiry.
            // ram_ready wins over expiry on the final allowed cycle.
            DACC, IACC: begin
               if (ram_ready) begin
                  result <= is_write ? '0 : ramload;
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
                  dhit_q <= (state == DACC);
                  ihit_q <= (state == IACC);
                  state  <= HIT;
               end else if (wd_cnt == WD_LAST) begin
                  ramREN  <= 1'b0;
                  ramWEN  <= 1'b0;
                  mem_err <= 1'b1;
                  state   <= ERR;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            // Completion: always a single cycle, then back through IDLE so
            // the requester's post-hit update is what gets sampled next.
            HIT: begin
               ihit_q <= 1'b0;
               dhit_q <= 1'b0;
               state  <= IDLE;
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A hit is only reported to a requester that is still asking for it;
   // a withdrawn request (pipeline flush) sees nothing.
   assign dhit  = dhit_q & (dREN | dWEN);
   assign ihit  = ihit_q & iREN;
   assign dload = dhit ? result : '0;
   assign iload = ihit ? result : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        halt;
   logic        iREN;
   logic [31:0] iaddr;
   logic        ihit;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dhit;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ram_ready;
   logic        mem_err;

   int errors = 0;
   int checks = 0;

   // ram_mem is the bench's RAM; ref_mem is what the requester believes
   // memory holds, updated from the writes it issues.
   logic [31:0] ram_mem [256];
   logic [31:0] ref_mem [256];

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST), .halt(halt),
      .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dhit(dhit), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
      .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int idx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      halt = 0; iREN = 0; dREN = 0; dWEN = 0;
      ram_ready = 0; ramload = $urandom;
   endtask

   // One scenario: an optional data request and an optional instruction
   // request, both first presented in cycle 0 with the arbiter idle.
   // Expected timing: an access seen in IDLE at cycle s strobes in cycles
   // s+1..s+L and hits in s+L+1; the hit cycle is followed by one IDLE cycle.
   task automatic scenario(input bit d_en, input bit d_w, input bit d_both,
                           input logic [31:0] da, input logic [31:0] ds, input int ld,
                           input bit i_en, input logic [31:0] ia, input int li,
                           input bit hl, input int d_drop);
      bit          i_act;
      bit          d_hit_ok;
      bit          dreq;
      int          istart, i_end, last;
      logic [31:0] exp_d, exp_i;
      bit          exp_rd, exp_wr, in_d;
      i_act    = i_en && !hl;
      d_hit_ok = d_en && (d_drop < 0);
      istart   = d_en ? ld + 2 : 0;
      i_end    = istart + li + 1;
      last     = 0;
      if (d_en && ld + 1 > last) last = ld + 1;
      if (i_act && i_end > last) last = i_end;
      if (hl && last < 10) last = 10;
      last = last + 2;
      exp_d = 32'h0;
      if (d_en) begin
         if (d_w) ref_mem[idx(da)] = ds;
         else     exp_d = ref_mem[idx(da)];
      end
      exp_i = ref_mem[idx(ia)];
      for (int t = 0; t <= last; t++) begin
         dreq   = d_en && (t <= ld + 1) && !((d_drop >= 0) && (t >= d_drop));
         dREN   = dreq && (!d_w || d_both);
         dWEN   = dreq && d_w;
         daddr  = (t == 0) ? da : $urandom;
         dstore = (t == 0) ? ds : $urandom;
         iREN   = i_en && (t <= (i_act ? i_end : last));
         iaddr  = (t <= istart) ? ia : $urandom;
         halt   = hl;
         #1;
         in_d   = d_en && (t >= 1) && (t <= ld);
         exp_rd = (in_d && !d_w) || (i_act && (t > istart) && (t <= istart + li));
         exp_wr = in_d && d_w;
         chk("ramREN", ramREN, exp_rd);
         chk("ramWEN", ramWEN, exp_wr);
         if (exp_rd || exp_wr) chk("ramaddr", ramaddr, in_d ? da : ia);
         if (exp_wr) chk("ramstore", ramstore, ds);
         chk("dhit", dhit, d_hit_ok && (t == ld + 1));
         if (d_hit_ok && (t == ld + 1)) chk("dload", dload, exp_d);
         chk("ihit", ihit, i_act && (t == i_end));
         if (i_act && (t == i_end)) chk("iload", iload, exp_i);
         chk("mem_err", mem_err, 0);
         // RAM responder
         ram_ready = (d_en && (t == ld)) || (i_act && (t == istart + li));
         ramload   = $urandom;
         if (ram_ready && ramREN) ramload = ram_mem[idx(ramaddr)];
         if (ram_ready && ramWEN) ram_mem[idx(ramaddr)] = ramstore;
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      bit d_en, d_w, d_both, i_en, hl;
      int ld, li, dd;
      for (int k = 0; k < 256; k++) begin
         ram_mem[k] = $urandom;
         ref_mem[k] = ram_mem[k];
      end
      RST = 1; idle_inputs();
      iaddr = 0; daddr = 0; dstore = 0;
      next_cycle();
      next_cycle();
      chk("rst_ihit", ihit, 0);
      chk("rst_dhit", dhit, 0);
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_ramstore", ramstore, 0);
      chk("rst_mem_err", mem_err, 0);
      RST = 0;
      next_cycle();

      // single read, ready on first strobe
      ram_mem[idx(32'h40)] = 32'h8C220004;
      ref_mem[idx(32'h40)] = 32'h8C220004;
      scenario(0, 0, 0, 0, 0, 1, 1, 32'h40, 1, 0, -1);
      // contention, both latency 3
      scenario(1, 0, 0, 32'h100, 0, 3, 1, 32'h44, 3, 0, -1);
      // write, then read it back
      scenario(1, 1, 0, 32'h200, 32'hDEADBEEF, 4, 0, 0, 1, 0, -1);
      scenario(1, 0, 0, 32'h200, 0, 2, 0, 0, 1, 0, -1);
      // halted instruction request
      scenario(0, 0, 0, 0, 0, 1, 1, 32'h48, 2, 1, -1);
      // data read withdrawn before ram_ready
      scenario(1, 0, 0, 32'h104, 0, 4, 0, 0, 1, 0, 2);
      // combined read+write treated as write
      scenario(1, 1, 1, 32'h208, 32'h12345678, 2, 1, 32'h208, 2, 0, -1);

      for (int n = 0; n < 40; n++) begin
         d_en   = $urandom_range(0, 1);
         d_w    = $urandom_range(0, 1);
         d_both = d_w && ($urandom_range(0, 1) == 1);
         i_en   = $urandom_range(0, 1);
         hl     = ($urandom_range(0, 4) == 0);
         ld     = $urandom_range(1, 7);
         li     = $urandom_range(1, 7);
         dd     = (d_en && ($urandom_range(0, 4) == 0)) ? $urandom_range(1, ld) : -1;
         scenario(d_en, d_w, d_both, $urandom & 32'h3FC, $urandom, ld,
                  i_en, $urandom & 32'h3FC, li, hl, dd);
      end

      // watchdog: RAM never ready, TIMEOUT=8
      dREN = 1; daddr = 32'h300;
      for (int t = 0; t <= 12; t++) begin
         #1;
         chk("to_ramREN", ramREN, (t >= 1) && (t <= 8));
         chk("to_ramWEN", ramWEN, 0);
         chk("to_mem_err", mem_err, t >= 9);
         chk("to_dhit", dhit, 0);
         ram_ready = 0;
         next_cycle();
      end
      RST = 1;
      next_cycle();
      RST = 0; dREN = 0;
      #1;
      chk("to_rst_mem_err", mem_err, 0);
      chk("to_rst_ramREN", ramREN, 0);
      next_cycle();
      scenario(0, 0, 0, 0, 0, 1, 1, 32'h40, 2, 0, -1);

      // reset in cycle 2 of a 5-cycle instruction read
      iREN = 1; iaddr = 32'h80;
      next_cycle();
      #1;
      chk("mr_strobe1", ramREN, 1);
      next_cycle();
      RST = 1;
      next_cycle();
      RST = 0; iREN = 0;
      #1;
      chk("mr_ihit", ihit, 0);
      chk("mr_dhit", dhit, 0);
      chk("mr_iload", iload, 0);
      chk("mr_dload", dload, 0);
      chk("mr_ramREN", ramREN, 0);
      chk("mr_ramWEN", ramWEN, 0);
      chk("mr_ramaddr", ramaddr, 0);
      chk("mr_ramstore", ramstore, 0);
      chk("mr_mem_err", mem_err, 0);
      for (int t = 0; t < 4; t++) begin
         ram_ready = 1; ramload = $urandom;
         next_cycle();
         #1;
         chk("mr_late_ihit", ihit, 0);
         chk("mr_late_ramREN", ramREN, 0);
      end
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the pipeline's memory request interface: converts per-cycle instruction/data requests (iREN, dREN/dWEN) into single-cycle ihit/dhit completion pulses.
- The pipeline's stall logic consumes those pulses.
- Arbitrates both request streams onto one single-ported RAM with variable latency; data accesses take priority over instruction fetches.
- Includes a watchdog that traps a hung RAM.

Parameters:
- AW, 32, address width (byte address; passed through unmodified)
- DW, 32, data width
- TIMEOUT, 64, max cycles an access may wait for ram_ready before error trap (>=2)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- halt  in  1  CPU halted; new instruction requests ignored while high
- iREN  in  1  instruction read request (level, held until ihit)
- iaddr  in  AW  instruction address
- ihit  out  1  one-cycle pulse: iload valid, instruction request complete
- iload  out  DW  instruction data, valid only while ihit=1
- dREN  in  1  data read request (level, held until dhit)
- dWEN  in  1  data write request (level, held until dhit)
- daddr  in  AW  data address
- dstore  in  DW  write data
- dhit  out  1  one-cycle pulse: data request complete (dload valid for reads)
- dload  out  DW  data read result, valid only while dhit=1
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  AW  RAM address
- ramstore  out  DW  RAM write data
- ramload  in  DW  RAM read data, valid when ram_ready=1
- ram_ready  in  1  RAM completes current access this cycle
- mem_err  out  1  sticky watchdog error flag

Behaviour:
- Reset (RST=1 at an edge, from any state, including mid-access):
  - state=IDLE; all outputs 0 (ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err); watchdog count=0.
  - An in-flight RAM access is abandoned without a hit.
- FSM states: IDLE, DACC, IACC, HIT, ERR.
- IDLE:
  - Sample requests each cycle.
  - If dREN|dWEN: latch daddr/dstore/op into request registers, go DACC.
  - Else if iREN & ~halt: latch iaddr, go IACC.
  - Else stay.
  - Data beats instruction when both present.
  - dREN&dWEN together is treated as a write.
- DACC / IACC:
  - Drive ramaddr/ramstore from the latched registers; ramREN (read) or ramWEN (write) held high every cycle in state.
  - Watchdog counts up from 0 per access.
  - On ram_ready=1: capture ramload into the result register; strobes drop next cycle; go HIT.
  - If the count reaches TIMEOUT with no ram_ready: go ERR.
- HIT (exactly one cycle):
  - Assert dhit (from DACC) or ihit (from IACC); dload/iload = captured result (writes: dload=0); then IDLE.
  - The hit is suppressed if the originating request is no longer asserted in the HIT cycle (requester withdrew, e.g. pipeline flush); the RAM write still took effect.
- Latency: request seen in IDLE at cycle 0 -> strobe cycles 1..N (ram_ready in cycle N) -> hit in cycle N+1.
  - Minimum request-to-hit is 2 cycles (ram_ready same cycle as first strobe).
  - Back-to-back accesses pass through IDLE, so there is at least 1 idle cycle between a hit and the next strobe. This guarantees the requester's post-hit update is sampled, not the stale request.
- A pending instruction request waits behind a data access. It is served after the data hit if still asserted and halt=0.
- Address/data inputs are sampled only in IDLE; changes during an access are ignored.
- ERR: mem_err=1, strobes 0, no hits; remains until reset.
- ihit and dhit are never high in the same cycle. Strobes are never high outside DACC/IACC. ramREN and ramWEN are never both high.

Test Plan:
- Single read:
  - Stimulus: iREN=1, iaddr=0x40; RAM ready on first strobe with ramload=0x8C220004.
  - Required: ramREN high 1 cycle at ramaddr=0x40; ihit pulse 2 cycles after request with iload=0x8C220004; ihit=0 next cycle.
- Contention:
  - Stimulus: iREN=1 and dREN=1, daddr=0x100 in the same cycle; RAM latency 3.
  - Required: data served first, dhit at cycle 4 with the RAM data; instruction strobe begins cycle 6, ihit at cycle 9.
- Write:
  - Stimulus: dWEN=1, daddr=0x200, dstore=0xDEADBEEF.
  - Required: ramWEN held with ramstore=0xDEADBEEF until ram_ready; dhit one pulse, dload=0; no ramREN.
- Halt/withdraw:
  - Stimulus: halt=1 with iREN=1.
  - Required: no strobe, no ihit for 10 cycles.
  - Stimulus: dREN dropped before ram_ready.
  - Required: access completes, no dhit.
- Timeout:
  - Stimulus: TIMEOUT=8, ram_ready held 0.
  - Required: mem_err=1 after 8 strobe cycles; strobes 0; RST clears to IDLE with mem_err=0.
- Reset mid-access:
  - Stimulus: RST in cycle 2 of a 5-cycle read.
  - Required: all outputs 0 next cycle; a later ram_ready produces no hit.
